// File: rtl/watch_alarm.sv
// ============================================================================
// watch_alarm : time-of-day counter with prescaler, day count, 12/24 h display
//               and a single daily alarm with timed ring and acknowledge.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module watch_alarm #(
  parameter int TICKS_PER_SEC = 1,
  parameter int ALARM_LEN     = 60,
  parameter int DAY_W         = 16
) (
  input  logic             Clk_5sec,
  input  logic             reset,
  input  logic             tick_en,
  input  logic             load,
  input  logic [5:0]       load_sec,
  input  logic [5:0]       load_min,
  input  logic [4:0]       load_hour,
  input  logic             alarm_set,
  input  logic [5:0]       alarm_min,
  input  logic [4:0]       alarm_hour,
  input  logic             alarm_en,
  input  logic             alarm_ack,
  input  logic             mode_12h,
  output logic [5:0]       seconds,
  output logic [5:0]       minutes,
  output logic [4:0]       hours,
  output logic [DAY_W-1:0] days,
  output logic             day_tick,
  output logic [4:0]       disp_hour,
  output logic             pm,
  output logic             alarm
);

  localparam int PS_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int RC_W = $clog2(ALARM_LEN + 1);
  localparam logic [PS_W-1:0] c_PS_LAST   = PS_W'(TICKS_PER_SEC - 1);
  localparam logic [RC_W-1:0] c_RING_INIT = RC_W'(ALARM_LEN);

  logic [PS_W-1:0] r_ps;
  logic [5:0]      r_alm_min;
  logic [4:0]      r_alm_hour;
  logic [RC_W-1:0] r_ring;

  logic       w_adv;
  logic       w_sec_wrap, w_min_wrap, w_hour_wrap, w_midnight;
  logic [5:0] w_nsec, w_nmin;
  logic [4:0] w_nhour;
  logic [5:0] w_ld_sec, w_ld_min, w_al_min;
  logic [4:0] w_ld_hour, w_al_hour;
  logic       w_match;

  // A load in the same cycle suppresses the advance entirely.
  assign w_adv       = tick_en && (r_ps == c_PS_LAST) && !load;
  assign w_sec_wrap  = (seconds == 6'd59);
  assign w_min_wrap  = (minutes == 6'd59);
  assign w_hour_wrap = (hours == 5'd23);
  assign w_midnight  = w_sec_wrap && w_min_wrap && w_hour_wrap;

  always_comb begin
    w_nsec  = w_sec_wrap ? 6'd0 : seconds + 6'd1;
    w_nmin  = minutes;
    w_nhour = hours;
    if (w_sec_wrap) begin
      w_nmin = w_min_wrap ? 6'd0 : minutes + 6'd1;
      if (w_min_wrap) w_nhour = w_hour_wrap ? 5'd0 : hours + 5'd1;
    end
  end

  assign w_ld_sec  = (load_sec   > 6'd59) ? 6'd0 : load_sec;
  assign w_ld_min  = (load_min   > 6'd59) ? 6'd0 : load_min;
  assign w_ld_hour = (load_hour  > 5'd23) ? 5'd0 : load_hour;
  assign w_al_min  = (alarm_min  > 6'd59) ? 6'd0 : alarm_min;
  assign w_al_hour = (alarm_hour > 5'd23) ? 5'd0 : alarm_hour;

  assign w_match = w_adv && alarm_en && (w_nsec == 6'd0) &&
                   (w_nmin == r_alm_min) && (w_nhour == r_alm_hour);

  always_ff @(posedge Clk_5sec or negedge reset) begin
    if (!reset) begin
      r_ps       <= '0;
      seconds    <= '0;
      minutes    <= '0;
      hours      <= '0;
      days       <= '0;
      day_tick   <= 1'b0;
      r_alm_min  <= '0;
      r_alm_hour <= '0;
      r_ring     <= '0;
      alarm      <= 1'b0;
    end else begin
      day_tick <= 1'b0;
      if (load) begin
        r_ps    <= '0;
        seconds <= w_ld_sec;
        minutes <= w_ld_min;
        hours   <= w_ld_hour;
      end else if (tick_en) begin
        r_ps <= (r_ps == c_PS_LAST) ? '0 : r_ps + 1'b1;
        if (w_adv) begin
          seconds <= w_nsec;
          minutes <= w_nmin;
          hours   <= w_nhour;
          if (w_midnight) begin
            days     <= days + 1'b1;
            day_tick <= 1'b1;
          end
        end
      end

      if (alarm_set) begin
        r_alm_min  <= w_al_min;
        r_alm_hour <= w_al_hour;
      end

      // Silence/disarm outranks a fresh trigger in the same cycle.
      if (alarm_ack || !alarm_en) begin
        alarm  <= 1'b0;
        r_ring <= '0;
      end else if (w_match) begin
        alarm  <= 1'b1;
        r_ring <= c_RING_INIT;
      end else if (alarm && w_adv) begin
        r_ring <= r_ring - 1'b1;
        if (r_ring <= RC_W'(1)) alarm <= 1'b0;
      end
    end
  end

  always_comb begin
    disp_hour = hours;
    pm        = 1'b0;
    if (mode_12h) begin
      pm = (hours >= 5'd12);
      if (hours == 5'd0)       disp_hour = 5'd12;
      else if (hours > 5'd12)  disp_hour = hours - 5'd12;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_watch_alarm.sv
// ============================================================================
// tb_watch_alarm : self-checking bench for watch_alarm (TICKS_PER_SEC=4, ALARM_LEN=3).
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_watch_alarm;
  localparam int TPS = 4;
  localparam int AL  = 3;
  localparam int DW  = 16;

  logic          Clk_5sec = 1'b0;
  logic          reset;
  logic          tick_en, load, alarm_set, alarm_en, alarm_ack, mode_12h;
  logic [5:0]    load_sec, load_min, alarm_min;
  logic [4:0]    load_hour, alarm_hour;
  logic [5:0]    seconds, minutes;
  logic [4:0]    hours, disp_hour;
  logic [DW-1:0] days;
  logic          day_tick, pm, alarm;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       ld;
    logic [5:0] s, m;
    logic [4:0] h;
    logic       m12;
    int         es, em, eh, ed, ep;
  } vec_t;

  typedef struct { int es, em, eh, ed, ep; } exp_t;

  vec_t vecs[9];
  exp_t sb[$];

  watch_alarm #(.TICKS_PER_SEC(TPS), .ALARM_LEN(AL), .DAY_W(DW)) dut (
    .Clk_5sec(Clk_5sec), .reset(reset), .tick_en(tick_en), .load(load),
    .load_sec(load_sec), .load_min(load_min), .load_hour(load_hour),
    .alarm_set(alarm_set), .alarm_min(alarm_min), .alarm_hour(alarm_hour),
    .alarm_en(alarm_en), .alarm_ack(alarm_ack), .mode_12h(mode_12h),
    .seconds(seconds), .minutes(minutes), .hours(hours), .days(days),
    .day_tick(day_tick), .disp_hour(disp_hour), .pm(pm), .alarm(alarm)
  );

  always #5 Clk_5sec = ~Clk_5sec;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk_5sec);
    #1;
  endtask

  // One full second from a cleared prescaler.
  task automatic adv1();
    tick_en = 1'b1;
    repeat (TPS) step();
    tick_en = 1'b0;
  endtask

  task automatic do_load(input int s, input int m, input int h);
    load = 1'b1; load_sec = 6'(s); load_min = 6'(m); load_hour = 5'(h);
    step();
    load = 1'b0;
  endtask

  task automatic chk_time(input string name, input int s, input int m, input int h);
    chk({name, ".sec"},  int'(seconds), s);
    chk({name, ".min"},  int'(minutes), m);
    chk({name, ".hour"}, int'(hours),   h);
  endtask

  initial begin
    exp_t e;
    reset = 1'b0; tick_en = 1'b0; load = 1'b0; alarm_set = 1'b0;
    alarm_en = 1'b0; alarm_ack = 1'b0; mode_12h = 1'b0;
    load_sec = '0; load_min = '0; load_hour = '0; alarm_min = '0; alarm_hour = '0;

    vecs[0] = '{1'b1, 6'd61, 6'd30, 5'd25, 1'b0,  0, 30,  0,  0, 0};
    vecs[1] = '{1'b1, 6'd0,  6'd0,  5'd0,  1'b1,  0,  0,  0, 12, 0};
    vecs[2] = '{1'b1, 6'd5,  6'd7,  5'd12, 1'b1,  5,  7, 12, 12, 1};
    vecs[3] = '{1'b1, 6'd59, 6'd59, 5'd13, 1'b1, 59, 59, 13,  1, 1};
    vecs[4] = '{1'b1, 6'd0,  6'd60, 5'd23, 1'b1,  0,  0, 23, 11, 1};
    vecs[5] = '{1'b1, 6'd10, 6'd20, 5'd9,  1'b0, 10, 20,  9,  9, 0};
    vecs[6] = '{1'b0, 6'd0,  6'd0,  5'd0,  1'b1, 10, 20,  9,  9, 0};
    vecs[7] = '{1'b1, 6'd30, 6'd45, 5'd23, 1'b0, 30, 45, 23, 23, 0};
    vecs[8] = '{1'b0, 6'd0,  6'd0,  5'd0,  1'b1, 30, 45, 23, 11, 1};

    // Reset state
    step(); step();
    chk_time("reset", 0, 0, 0);
    chk("reset.days", int'(days), 0);
    chk("reset.day_tick", int'(day_tick), 0);
    chk("reset.alarm", int'(alarm), 0);
    reset = 1'b1;

    // Prescaler period, then a 3-cycle stall stretching it to 7
    tick_en = 1'b1;
    repeat (3) step();
    chk("ps.edge3", int'(seconds), 0);
    step();
    chk("ps.edge4", int'(seconds), 1);
    repeat (2) step();
    tick_en = 1'b0;
    repeat (3) step();
    tick_en = 1'b1;
    step();
    chk("ps.stretch6", int'(seconds), 1);
    step();
    chk("ps.stretch7", int'(seconds), 2);

    // Asynchronous reset mid-count clears prescaler too
    repeat (2) step();
    #2 reset = 1'b0;
    #1 chk("areset.sec", int'(seconds), 0);
    @(negedge Clk_5sec);
    reset = 1'b1;
    step(); step(); step();
    chk("areset.edge3", int'(seconds), 0);
    step();
    chk("areset.edge4", int'(seconds), 1);
    tick_en = 1'b0;

    // Table: loads with clamping and display mapping
    foreach (vecs[i]) begin
      load = vecs[i].ld; load_sec = vecs[i].s; load_min = vecs[i].m;
      load_hour = vecs[i].h; mode_12h = vecs[i].m12;
      sb.push_back('{vecs[i].es, vecs[i].em, vecs[i].eh, vecs[i].ed, vecs[i].ep});
      step();
      load = 1'b0;
      e = sb.pop_front();
      chk($sformatf("vec%0d.sec", i),  int'(seconds),   e.es);
      chk($sformatf("vec%0d.min", i),  int'(minutes),   e.em);
      chk($sformatf("vec%0d.hour", i), int'(hours),     e.eh);
      chk($sformatf("vec%0d.disp", i), int'(disp_hour), e.ed);
      chk($sformatf("vec%0d.pm", i),   int'(pm),        e.ep);
    end
    mode_12h = 1'b0;

    // Load wins over a coincident advance and clears the prescaler
    do_load(30, 20, 10);
    tick_en = 1'b1;
    repeat (3) step();
    load = 1'b1; load_sec = 6'd3; load_min = 6'd2; load_hour = 5'd1;
    step();
    load = 1'b0;
    chk_time("ldadv", 3, 2, 1);
    repeat (3) step();
    chk("ldadv.edge3", int'(seconds), 3);
    step();
    chk("ldadv.edge4", int'(seconds), 4);
    tick_en = 1'b0;

    // Midnight rollover
    do_load(58, 59, 23);
    adv1();
    chk_time("roll1", 59, 59, 23);
    chk("roll1.days", int'(days), 0);
    adv1();
    chk_time("roll2", 0, 0, 0);
    chk("roll2.days", int'(days), 1);
    chk("roll2.day_tick", int'(day_tick), 1);
    step();
    chk("roll3.day_tick", int'(day_tick), 0);
    chk("roll3.days", int'(days), 1);

    // Alarm rings for ALARM_LEN advances
    alarm_set = 1'b1; alarm_min = 6'd0; alarm_hour = 5'd7; alarm_en = 1'b1;
    step();
    alarm_set = 1'b0;
    do_load(59, 59, 6);
    chk("alm.preload", int'(alarm), 0);
    adv1();
    chk("alm.trig", int'(alarm), 1);
    adv1();
    chk("alm.ring1", int'(alarm), 1);
    adv1();
    chk("alm.ring2", int'(alarm), 1);
    adv1();
    chk("alm.ring3", int'(alarm), 0);

    // Acknowledge after one advance
    do_load(59, 59, 6);
    adv1();
    chk("ack.trig", int'(alarm), 1);
    adv1();
    chk("ack.ring1", int'(alarm), 1);
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
    chk("ack.cleared", int'(alarm), 0);
    adv1();
    chk("ack.stays", int'(alarm), 0);

    // Loading the exact alarm time never triggers
    do_load(0, 0, 7);
    chk("ldmatch", int'(alarm), 0);
    adv1();
    chk("ldmatch.adv", int'(alarm), 0);

    // Disarmed during the matching advance
    do_load(59, 59, 6);
    alarm_en = 1'b0;
    adv1();
    chk_time("dis", 0, 0, 7);
    chk("dis.alarm", int'(alarm), 0);

    // Out-of-range alarm clamps to 00:00; ring then cut by disarm
    alarm_set = 1'b1; alarm_min = 6'd60; alarm_hour = 5'd24; alarm_en = 1'b1;
    step();
    alarm_set = 1'b0;
    do_load(59, 59, 23);
    adv1();
    chk("clamp.alarm", int'(alarm), 1);
    chk("clamp.day_tick", int'(day_tick), 1);
    chk("clamp.days", int'(days), 2);
    alarm_en = 1'b0;
    step();
    chk("disarm.alarm", int'(alarm), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/watch_alarm.md
# watch_alarm

Parametrised time-of-day counter with prescaler, run-time time load, day counter, 12/24-hour display mode and a single daily alarm with timed ring and acknowledge. It replaces the basic seconds/minutes/hours watch in the clocking subsystem. It sits between the slow system clock domain and the display/buzzer drivers.

## Interface
- TICKS_PER_SEC, default 1: number of enabled clock cycles per one-second advance (≥1).
- ALARM_LEN, default 60: number of second advances the alarm output stays high unless acknowledged (≥1).
- DAY_W, default 16: width of the day counter.
- Clk_5sec  input  1  clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- tick_en  input  1  prescaler count enable for this cycle.
- load  input  1  load time from load_* inputs this cycle.
- load_sec  input  6  seconds value to load.
- load_min  input  6  minutes value to load.
- load_hour  input  5  hours value to load, 24 h format.
- alarm_set  input  1  capture alarm_min and alarm_hour into the alarm registers.
- alarm_min  input  6  alarm minute.
- alarm_hour  input  5  alarm hour, 24 h format.
- alarm_en  input  1  alarm armed.
- alarm_ack  input  1  silence a ringing alarm.
- mode_12h  input  1  selects 12-hour display.
- seconds  output  6  0..59, registered.
- minutes  output  6  0..59, registered.
- hours  output  5  0..23, registered, always 24 h.
- days  output  DAY_W  day count, registered, wraps to 0 after all-ones.
- day_tick  output  1  one-cycle pulse on midnight rollover, registered.
- disp_hour  output  5  display hour, combinational from hours and mode_12h.
- pm  output  1  PM flag, combinational.
- alarm  output  1  alarm ringing, registered.

## Operation
- Reset (reset=0, asynchronous): seconds, minutes, hours, days, prescaler, alarm registers (hour and minute), ring counter, alarm and day_tick all go to 0.
- Prescaler counts 0..TICKS_PER_SEC-1 on cycles with tick_en=1 and holds when tick_en=0.
- A second advance occurs on a tick_en cycle with the prescaler at TICKS_PER_SEC-1; the prescaler then returns to 0. With TICKS_PER_SEC=1, every tick_en cycle is an advance.
- Advance carries:
  - seconds 59→0 with minutes+1;
  - minutes 59→0 with hours+1;
  - hours 23→0 with days+1 and day_tick=1 for the next cycle.
  - days wraps from 2^DAY_W-1 to 0.
  - seconds, minutes and hours never hold 60, 60 or 24.
- load=1 has priority over advance in the same cycle:
  - seconds, minutes and hours take the load values; the prescaler clears to 0; days is unchanged; no day_tick.
  - Any out-of-range field (sec>59, min>59, hour>23) is loaded as 0. In-range fields load normally.
- alarm_set=1 captures alarm_hour and alarm_min, with the same range clamping to 0. It is independent of load.
- Alarm trigger: an advance (never a load) produces hours:minutes:seconds == alarm_hour:alarm_min:00 while alarm_en=1. Then alarm=1 on that edge and the ring counter is set to ALARM_LEN.
- While ringing, each advance decrements the ring counter. When it reaches 0, alarm clears on that edge.
- alarm_ack=1 or alarm_en=0 clears alarm and the ring counter on the next edge. These take priority over a trigger in the same cycle.
- Display:
  - mode_12h=0: disp_hour=hours, pm=0.
  - mode_12h=1: hours 0 gives 12; 1..12 unchanged; 13..23 gives hours-12. pm=1 when hours≥12.

## Timing
- Advance latency: registered outputs change on the same rising edge that samples the terminal tick_en. There is one edge from the TICKS_PER_SEC-th enabled cycle to new values.
- load and alarm_set take effect on the sampling edge and are visible in the following cycle.
- day_tick is high exactly one cycle, beginning at the rollover edge.
- alarm rises at the trigger edge. After ALARM_LEN advances it falls on the edge of the ALARM_LEN-th advance.
- Reset asserted mid-count or mid-ring clears all state immediately. The first advance after release needs a full TICKS_PER_SEC enabled cycles.
- disp_hour and pm settle combinationally in the same cycle as hours or mode_12h changes.

## Test plan
- TICKS_PER_SEC=4, reset, tick_en=1 continuously: seconds=1 after 4 edges. tick_en low for 3 cycles mid-count stretches the period to 7 cycles.
- Load 23:59:58 with days=0, then 2 advances: time 00:00:00, days=1, day_tick high for exactly one cycle.
- Load sec=61, min=30, hour=25: result 00:30:00. load and advance in the same cycle: load value wins.
- Alarm 07:00, alarm_en=1, ALARM_LEN=3, load 06:59:59, one advance: alarm=1. It falls after 3 further advances. Repeat with alarm_ack after 1 advance: alarm=0 next edge.
- Load exactly 07:00:00 with the alarm set to 07:00: alarm stays 0. alarm_en=0 during the match advance: no ring.
- mode_12h=1: hours 0→disp 12, pm 0; hours 12→disp 12, pm 1; hours 13→disp 1, pm 1; hours 23→disp 11, pm 1.
